// File: rtl/unstriping_pkg.sv
// rtl/unstriping_pkg.sv - shared types and constants for the two-lane unstriping sequencer
package unstriping_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DEFAULT_DATA_W = 32;
    localparam int SKEW_CNT_W     = 8;

endpackage

// File: rtl/unstriping_skew_mon.sv
// rtl/unstriping_skew_mon.sv - counts cycles the expected lane starves while the other lane holds data
module unstriping_skew_mon
    import unstriping_pkg::*;
#(
    parameter int SKEW_MAX = 8
) (
    input  logic clk_2f,
    input  logic reset_L,
    input  logic enable,
    input  logic clear,
    input  logic fire,
    input  logic ready_in,
    input  logic exp_empty,
    input  logic other_empty,
    output logic skew_hit
);

    logic [SKEW_CNT_W-1:0] cnt;
    logic                  skewed;

    assign skewed   = ready_in & exp_empty & ~other_empty;
    // A fire in the same cycle always beats the threshold.
    assign skew_hit = enable & ~fire & skewed & (cnt == SKEW_CNT_W'(SKEW_MAX - 1));

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (fire || (exp_empty && other_empty)) begin
                cnt <= '0;
            end else if (skewed) begin
                cnt <= cnt + SKEW_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/unstriping_ctrl.sv
// rtl/unstriping_ctrl.sv - alternating two-lane FIFO reader restoring striped word order
module unstriping_ctrl
    import unstriping_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SKEW_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic              empty0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              pop0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              pop1,
    input  logic              ready_in,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              exp_lane,
    output logic              skew_err,
    output logic              idle,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t            state, state_nxt;
    logic              exp_empty, other_empty, fire, skew_hit, err_clear;
    logic [DATA_W-1:0] exp_data;

    always_comb begin
        exp_empty   = (exp_lane == LANE1) ? empty1 : empty0;
        other_empty = (exp_lane == LANE1) ? empty0 : empty1;
        exp_data    = (exp_lane == LANE1) ? data_in1 : data_in0;
        fire        = (state == ST_RUN) & ready_in & ~exp_empty;
        pop0        = fire & (exp_lane == LANE0);
        pop1        = fire & (exp_lane == LANE1);
        err_clear   = (state == ST_ERROR) & clear_err;
        idle        = (state == ST_IDLE);

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (skew_hit)     state_nxt = ST_ERROR;
                else if (!empty0) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (skew_hit) state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
                if (clear_err) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            exp_lane  <= LANE0;
            skew_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            valid_out <= fire;
            if (fire) begin
                data_out <= exp_data;
                exp_lane <= ~exp_lane;
                word_cnt <= word_cnt + CNT_W'(1);
            end else if (err_clear) begin
                exp_lane <= LANE0;
            end
            if (skew_hit)       skew_err <= 1'b1;
            else if (err_clear) skew_err <= 1'b0;
        end
    end

    unstriping_skew_mon #(
        .SKEW_MAX (SKEW_MAX)
    ) u_skew_mon (
        .clk_2f      (clk_2f),
        .reset_L     (reset_L),
        .enable      (state != ST_ERROR),
        .clear       (err_clear),
        .fire        (fire),
        .ready_in    (ready_in),
        .exp_empty   (exp_empty),
        .other_empty (other_empty),
        .skew_hit    (skew_hit)
    );

endmodule

// File: tb/tb_unstriping_ctrl.sv
// tb/tb_unstriping_ctrl.sv - scoreboard bench for unstriping_ctrl with lane FIFO models
module tb_unstriping_ctrl;

    localparam int DATA_W   = 32;
    localparam int SKEW_MAX = 8;
    localparam int CNT_W    = 4;

    logic              clk_2f = 1'b0;
    logic              reset_L = 1'b0;
    logic              empty0, empty1, pop0, pop1;
    logic              ready_in, clear_err;
    logic [DATA_W-1:0] data_in0, data_in1, data_out;
    logic              valid_out, exp_lane, skew_err, idle;
    logic [CNT_W-1:0]  word_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_q[$];
    int          model_cnt = 0;
    bit          seq_lane = 1'b0;
    bit          pop_par = 1'b0;
    bit          last_pop = 1'b0;

    unstriping_ctrl #(
        .DATA_W   (DATA_W),
        .SKEW_MAX (SKEW_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .empty0    (empty0),
        .data_in0  (data_in0),
        .pop0      (pop0),
        .empty1    (empty1),
        .data_in1  (data_in1),
        .pop1      (pop1),
        .ready_in  (ready_in),
        .clear_err (clear_err),
        .data_out  (data_out),
        .valid_out (valid_out),
        .exp_lane  (exp_lane),
        .skew_err  (skew_err),
        .idle      (idle),
        .word_cnt  (word_cnt)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        empty0   = (q0.size() == 0);
        empty1   = (q1.size() == 0);
        data_in0 = empty0 ? '0 : q0[0];
        data_in1 = empty1 ? '0 : q1[0];
    endtask

    // Original stream order: word k lands in lane k%2.
    task automatic push_word();
        logic [31:0] w;
        w = $urandom();
        if (seq_lane) q1.push_back(w);
        else          q0.push_back(w);
        exp_q.push_back(w);
        seq_lane = ~seq_lane;
        refresh();
    endtask

    task automatic step();
        bit p0, p1;
        @(negedge clk_2f);
        p0 = pop0;
        p1 = pop1;
        chk("single_pop", 32'(p0 & p1), 32'd0);
        if (!ready_in) chk("pop_while_stalled", 32'(p0 | p1), 32'd0);
        chk("pop0_on_empty", 32'(p0 && q0.size() == 0), 32'd0);
        chk("pop1_on_empty", 32'(p1 && q1.size() == 0), 32'd0);
        chk("valid_latency", 32'(valid_out), 32'(last_pop));
        chk("exp_lane", 32'(exp_lane), 32'(pop_par));
        if (p0 | p1) begin
            chk("pop_lane_order", 32'(p1), 32'(pop_par));
            pop_par = ~pop_par;
        end
        last_pop = p0 | p1;
        @(posedge clk_2f);
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic flush_model();
        q0.delete();
        q1.delete();
        exp_q.delete();
        model_cnt = 0;
        seq_lane  = 1'b0;
        pop_par   = 1'b0;
        last_pop  = 1'b0;
        refresh();
    endtask

    always @(negedge clk_2f) begin
        if (reset_L && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", data_out);
            end else begin
                chk("data_out", data_out, exp_q.pop_front());
                model_cnt = (model_cnt + 1) % (1 << CNT_W);
                chk("word_cnt", 32'(word_cnt), 32'(model_cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        ready_in  = 1'b1;
        clear_err = 1'b0;
        flush_model();
        #1;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_skew_err", 32'(skew_err), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_exp_lane", 32'(exp_lane), 32'd0);
        chk("rst_pops", 32'(pop0 | pop1), 32'd0);
        repeat (2) @(posedge clk_2f);
        @(negedge clk_2f);
        reset_L = 1'b1;
        @(posedge clk_2f);
        #1;

        // Four words across both lanes, full-rate drain
        repeat (4) push_word();
        repeat (7) step();
        chk("t1_drained", exp_q.size(), 32'd0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd4);
        chk("t1_idle", 32'(idle), 32'd0);

        // Lane 1 only: skew builds, holds while stalled, then errors
        q1.push_back(32'hB1B1_0001);
        refresh();
        repeat (4) step();
        ready_in = 1'b0;
        repeat (3) step();
        ready_in = 1'b1;
        repeat (3) step();
        chk("t2_skew_before_max", 32'(skew_err), 32'd0);
        step();
        chk("t2_skew_at_max", 32'(skew_err), 32'd1);
        chk("t2_not_idle", 32'(idle), 32'd0);
        repeat (2) step();
        chk("t2_err_sticky", 32'(skew_err), 32'd1);
        clear_err = 1'b1;
        q1.delete();
        refresh();
        step();
        clear_err = 1'b0;
        pop_par   = 1'b0;
        seq_lane  = 1'b0;
        chk("t2_cleared", 32'(skew_err), 32'd0);
        chk("t2_idle", 32'(idle), 32'd1);
        chk("t2_exp_lane", 32'(exp_lane), 32'd0);

        // Mid-burst stall
        repeat (6) push_word();
        repeat (3) step();
        ready_in = 1'b0;
        repeat (3) step();
        ready_in = 1'b1;
        repeat (8) step();
        chk("t3_drained", exp_q.size(), 32'd0);
        chk("t3_no_err", 32'(skew_err), 32'd0);

        // Random in-order arrivals, random backpressure, stray clear_err pulses
        repeat (300) begin
            ready_in  = ($urandom_range(0, 3) != 0);
            clear_err = ($urandom_range(0, 15) == 0);
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) if (exp_q.size() < 8) push_word();
            step();
        end
        clear_err = 1'b0;
        ready_in  = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        chk("rand_drained", exp_q.size(), 32'd0);
        chk("rand_no_err", 32'(skew_err), 32'd0);

        // Lane 1 lagging lane 0 by five cycles is not skew
        push_word();
        repeat (5) step();
        push_word();
        repeat (4) step();
        chk("t4_drained", exp_q.size(), 32'd0);
        chk("t4_no_err", 32'(skew_err), 32'd0);

        // Asynchronous reset mid-burst
        repeat (6) push_word();
        repeat (3) step();
        #2;
        reset_L = 1'b0;
        #1;
        chk("t5_data_out", data_out, 32'd0);
        chk("t5_valid_out", 32'(valid_out), 32'd0);
        chk("t5_word_cnt", 32'(word_cnt), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_exp_lane", 32'(exp_lane), 32'd0);
        flush_model();
        chk("t5_pops", 32'(pop0 | pop1), 32'd0);
        @(negedge clk_2f);
        reset_L = 1'b1;
        @(posedge clk_2f);
        #1;

        // Restart from lane 0 and wrap the 4-bit counter
        repeat (17) push_word();
        repeat (22) step();
        chk("t6_drained", exp_q.size(), 32'd0);
        chk("t6_word_cnt_wrap", 32'(word_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unstriping_ctrl.md
Name: unstriping_ctrl

Overview:
Sequencer for the two-lane unstriping path on the clk_2f domain. Pops words from the lane-0 and lane-1 first-word-fall-through FIFOs in strict alternation, starting at lane 0, to restore the striper's original word order. Drives a single registered output stream with downstream backpressure. Detects lane skew and latches a sticky error.

Parameters:
DATA_W, 32, width of each lane word and of data_out
SKEW_MAX, 8, consecutive cycles the expected lane may be empty while the other lane holds data before skew error; legal 1..255
CNT_W, 16, width of delivered-word counter

Ports:
clk_2f  in  1  sole clock
reset_L  in  1  asynchronous active-low reset
empty0  in  1  lane-0 FIFO empty; data_in0 valid when low
data_in0  in  DATA_W  lane-0 FIFO head word (show-ahead)
pop0  out  1  lane-0 FIFO read strobe, combinational
empty1  in  1  lane-1 FIFO empty
data_in1  in  DATA_W  lane-1 FIFO head word (show-ahead)
pop1  out  1  lane-1 FIFO read strobe, combinational
ready_in  in  1  downstream may accept a word this cycle
clear_err  in  1  synchronous clear of the skew error, pulse
data_out  out  DATA_W  reassembled word, registered
valid_out  out  1  data_out qualifier, registered, one cycle per word
exp_lane  out  1  lane the next pop targets, registered
skew_err  out  1  sticky lane-skew flag, registered
idle  out  1  high in IDLE state
word_cnt  out  CNT_W  words delivered since reset, wraps

Behaviour:
- Reset (reset_L low, async): state=IDLE, exp_lane=0, skew counter=0, data_out=0, valid_out=0, skew_err=0, word_cnt=0. pop0=pop1=0 while reset asserted.
- States: IDLE, RUN, ERROR.
- IDLE: idle=1. Go to RUN when empty0=0. Lane-1 data present with lane 0 empty does not start the sequence, but does count skew.
- RUN, fire condition: fire = ready_in & ~empty[exp_lane].
  - pop[exp_lane]=fire; the other pop is 0. At most one pop per cycle.
  - On fire: data_out <= data_in[exp_lane], valid_out <= 1, exp_lane toggles, word_cnt+1 (wraps mod 2^CNT_W), skew counter cleared.
  - Otherwise valid_out <= 0 and data_out holds.
  - Latency: one cycle from pop to valid_out.
  - Peak throughput is one word per clk_2f cycle, lanes alternating.
- Skew counter (IDLE and RUN):
  - Increments when ~ready_in is false, the expected lane is empty, and the other lane is not empty.
  - Clears on fire, and whenever both lanes are empty.
  - Holds when ready_in=0.
  - On reaching SKEW_MAX: skew_err <= 1, state -> ERROR.
- ERROR: no pops, valid_out=0, exp_lane holds.
  - clear_err=1 -> skew_err <= 0, counter=0, exp_lane <= 0, state -> IDLE. FIFO flushing is left to the system.
  - clear_err is ignored outside ERROR.
- Backpressure: ready_in=0 blocks popping in every state. In-flight data_out/valid_out are not held; valid_out drops the next cycle. Downstream must size ready_in as almost-full with one slot of slack.
- Simultaneous events:
  - Fire and a skew threshold in the same cycle: fire wins and the counter clears.
  - clear_err and reset: reset wins.
- Reset mid-operation: everything returns to reset values immediately. Any word held in data_out is discarded.
- idle deasserts the cycle after leaving IDLE.

Decomposition:
- Shared package unstriping_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_ERROR=2'd2
  - LANE0/LANE1 constants
  - default DATA_W
- One natural sub-module: unstriping_skew_mon, holding the skew counter and threshold compare, with output skew_hit.
- The mux (output register plus lane select) stays inline.

Test Plan:
1. Reset, then lane0 holds A0,A2 and lane1 holds A1,A3, ready_in=1 -> pops alternate 0,1,0,1; data_out sequence A0,A1,A2,A3 on 4 consecutive cycles; word_cnt=4; idle=0.
2. Lane1 holds B1 only, lane0 empty, SKEW_MAX=8 -> no pops; skew_err=1 after 8 cycles; state ERROR. clear_err pulse -> skew_err=0, idle=1.
3. Streaming with ready_in low for 3 cycles mid-burst -> no pops and valid_out=0 during the stall; order preserved after resume; skew counter does not advance.
4. Lane0 gets word C0 while lane1 data arrives 5 cycles later (SKEW_MAX=8) -> C0 out, 5-cycle gap, then C1; no error.
5. Assert reset_L low asynchronously between clock edges during a burst -> outputs zero immediately; on release, sequence restarts at lane 0.
6. word_cnt with CNT_W=4: deliver 17 words -> word_cnt=1.
